// File: rtl/pe_src_arbiter2.sv
// ---------------------------------------------------------------------------
// pe_src_arbiter2
// Two-requester round-robin burst arbiter. It produces the one-hot select for
// the downstream 2:1 data mux and passes valid/ready between the selected
// source and the PE-side consumer. A grant is held for a whole burst, and the
// burst ends on a beat that carries the last flag.
//
// Parameters:
//   MAX_BURST  beat count above which a burst without last is an overrun
//   CNT_WIDTH  beat counter width, must be able to hold MAX_BURST+1
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester valid (bit0 = requester 0, bit1 = requester 1)
//   req_last   per-requester last-beat flag, qualified by req_valid
//   req_ready  per-requester ready, only the granted bit can be 1
//   out_ready  consumer ready
//   out_valid  valid toward the consumer, aligned with the mux output
//   out_last   last flag of the granted requester
//   sel        one-hot mux select: 00 idle, 01 requester 0, 10 requester 1
//   burst_err  one-cycle pulse on the beat that overruns MAX_BURST
//
// Optional feature (macro PE_SRC_ARB_STATS_EN):
//   grant_cnt0 / grant_cnt1  16-bit wrapping counts of bursts granted
//   to requester 0 / requester 1.
// ---------------------------------------------------------------------------
module pe_src_arbiter2 #(
    parameter int MAX_BURST = 64,
    parameter int CNT_WIDTH = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_last,
    output logic [1:0] sel,
    output logic       burst_err
`ifdef PE_SRC_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BEAT_LIMIT = CNT_WIDTH'(MAX_BURST);
    localparam logic [CNT_WIDTH-1:0] BEAT_SAT   = CNT_WIDTH'(MAX_BURST + 1);

    state_t               state;
    logic                 rr_pref;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 xfer;
    logic                 xfer_last;
    logic [1:0]           other_sel;
    logic                 grant_new;
    logic [1:0]           grant_sel;

    // Handshake outputs come straight from the select register so they stay
    // aligned with the mux; nothing here adds a cycle of latency.
    always_comb begin
        out_valid = |(req_valid & sel);
        out_last  = |(req_last & req_valid & sel);
        req_ready = sel & {2{out_ready}};
        xfer      = out_valid & out_ready;
        xfer_last = xfer & out_last;
        other_sel = {sel[0], sel[1]};
        // beat_cnt holds the transfers already done, so this transfer is beat
        // MAX_BURST+1 exactly when the count equals MAX_BURST; saturation
        // keeps the count from ever coming back to that value in one burst.
        burst_err = xfer & ~out_last & (beat_cnt == BEAT_LIMIT);
    end

    // Decide whether a new grant is taken at the next edge and for whom.
    // From IDLE any valid requester is granted, with the round-robin pointer
    // breaking ties. When a burst ends, the other requester is handed the
    // grant directly if it is waiting; the finishing requester's valid in that
    // cycle belongs to its last beat, so its next burst is picked up from IDLE.
    always_comb begin
        grant_new = 1'b0;
        grant_sel = 2'b00;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_new = 1'b1;
                    if (req_valid == 2'b11) begin
                        grant_sel = rr_pref ? 2'b10 : 2'b01;
                    end else begin
                        grant_sel = req_valid;
                    end
                end
            end
            GRANT: begin
                if (xfer_last && |(req_valid & other_sel)) begin
                    grant_new = 1'b1;
                    grant_sel = other_sel;
                end
            end
            default: begin
                grant_new = 1'b0;
                grant_sel = 2'b00;
            end
        endcase
    end

    // Arbiter state, select register, round-robin pointer and beat counter.
    // The pointer moves to the other requester whenever a burst completes;
    // an abandoned burst (reset) leaves it at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'b00;
            rr_pref  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (grant_new) begin
                state    <= GRANT;
                sel      <= grant_sel;
                beat_cnt <= '0;
            end else if (xfer_last) begin
                state    <= IDLE;
                sel      <= 2'b00;
                beat_cnt <= '0;
            end else if (xfer && (beat_cnt != BEAT_SAT)) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
            if (xfer_last) begin
                rr_pref <= sel[0];
            end
        end
    end

`ifdef PE_SRC_ARB_STATS_EN
    // Burst statistics: each counter steps on the edge that asserts a fresh
    // grant for its requester and wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else if (grant_new) begin
            if (grant_sel[0]) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (grant_sel[1]) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`else
    // Statistics disabled: no grant counters are built.
`endif

endmodule

// File: tb/tb_pe_src_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_pe_src_arbiter2
// Directed bench for pe_src_arbiter2 with MAX_BURST reduced to 4. Each step
// drives the requester inputs, records the expected outputs for that cycle
// in a queue and compares them against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_pe_src_arbiter2;

    localparam int MAX_BURST = 4;
    localparam int CNT_WIDTH = 3;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_last;
    logic [1:0] req_ready;
    logic       out_ready;
    logic       out_valid;
    logic       out_last;
    logic [1:0] sel;
    logic       burst_err;
`ifdef PE_SRC_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    typedef struct {
        logic [1:0] sel;
        logic [1:0] rdy;
        logic       ov;
        logic       ol;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sbQueue[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    pe_src_arbiter2 #(
        .MAX_BURST(MAX_BURST),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .sel       (sel),
        .burst_err (burst_err)
`ifdef PE_SRC_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Record what the outputs must look like for the inputs now being driven,
    // given the select value the arbiter is expected to hold this cycle.
    task automatic pushExpected(input logic [1:0] esel, input logic eerr, input string tag);
        exp_t e;
        e.sel = esel;
        e.rdy = esel & {2{out_ready}};
        e.ov  = |(req_valid & esel);
        e.ol  = |(req_last & req_valid & esel);
        e.err = eerr;
        e.tag = tag;
        sbQueue.push_back(e);
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput();
        exp_t e;
        testsRun++;
        assert (sbQueue.size() != 0) else begin
            testsFailed++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected a pending entry");
        end
        if (sbQueue.size() == 0) return;
        e = sbQueue.pop_front();
        testsRun++;
        assert (sel === e.sel) else begin
            testsFailed++;
            $error("[TB] FAIL %s sel: observed %b expected %b", e.tag, sel, e.sel);
        end
        testsRun++;
        assert (req_ready === e.rdy) else begin
            testsFailed++;
            $error("[TB] FAIL %s req_ready: observed %b expected %b", e.tag, req_ready, e.rdy);
        end
        testsRun++;
        assert (out_valid === e.ov) else begin
            testsFailed++;
            $error("[TB] FAIL %s out_valid: observed %b expected %b", e.tag, out_valid, e.ov);
        end
        testsRun++;
        assert (out_last === e.ol) else begin
            testsFailed++;
            $error("[TB] FAIL %s out_last: observed %b expected %b", e.tag, out_last, e.ol);
        end
        testsRun++;
        assert (burst_err === e.err) else begin
            testsFailed++;
            $error("[TB] FAIL %s burst_err: observed %b expected %b", e.tag, burst_err, e.err);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, check on the
    // falling edge, then move to just after the next rising edge.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] l, input logic r,
                                 input logic [1:0] esel, input logic eerr, input string tag);
        req_valid = v;
        req_last  = l;
        out_ready = r;
        pushExpected(esel, eerr, tag);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input string tag);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_last  = 2'b00;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        pushExpected(2'b00, 1'b0, tag);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_last  = 2'b00;
        out_ready = 1'b0;

        // Reset state, then a 3-beat burst from requester 0.
        resetDut("reset");
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, "t1 idle");
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, "t1 beat1");
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, "t1 beat2");
        applyStimulus(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, "t1 beat3");
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "t1 released");

        // Both requesters streaming 2-beat bursts: grants alternate with no bubble.
        resetDut("t2 reset");
        applyStimulus(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, "t2 idle");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, $sformatf("t2 r0b1 k%0d", k));
            applyStimulus(2'b11, 2'b01, 1'b1, 2'b01, 1'b0, $sformatf("t2 r0b2 k%0d", k));
            applyStimulus(2'b11, 2'b00, 1'b1, 2'b10, 1'b0, $sformatf("t2 r1b1 k%0d", k));
            applyStimulus(2'b11, 2'b10, 1'b1, 2'b10, 1'b0, $sformatf("t2 r1b2 k%0d", k));
        end
        applyStimulus(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, "t2 r0 single");
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "t2 idle end");

        // Requester 0 burst with out_ready toggling; only ready cycles transfer.
        applyStimulus(2'b01, 2'b00, 1'b0, 2'b00, 1'b0, "t3 idle");
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, "t3 b1 rdy");
        applyStimulus(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, "t3 b2 stall");
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, "t3 b2 rdy");
        applyStimulus(2'b01, 2'b01, 1'b0, 2'b01, 1'b0, "t3 b3 stall");
        applyStimulus(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, "t3 b3 rdy");
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "t3 released");

        // Requester 1 sends 6 beats (valid drops once mid-burst): error on beat 5.
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, "t4 idle");
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b10, 1'b0, "t4 beat1");
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b10, 1'b0, "t4 beat2");
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b10, 1'b0, "t4 gap");
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b10, 1'b0, "t4 beat3");
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b10, 1'b0, "t4 beat4");
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, "t4 beat5");
        applyStimulus(2'b10, 2'b10, 1'b1, 2'b10, 1'b0, "t4 beat6");
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "t4 released");

        // A long overrun burst: the error pulse must not repeat.
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, "t4b idle");
        for (int b = 1; b <= 14; b++) begin
            applyStimulus(2'b10, (b == 14) ? 2'b10 : 2'b00, 1'b1, 2'b10, (b == 5) ? 1'b1 : 1'b0,
                          $sformatf("t4b beat%0d", b));
        end
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "t4b released");

        // Exactly MAX_BURST beats ending in last is legal.
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, "t5 idle");
        for (int b = 1; b <= MAX_BURST; b++) begin
            applyStimulus(2'b01, (b == MAX_BURST) ? 2'b01 : 2'b00, 1'b1, 2'b01, 1'b0,
                          $sformatf("t5 beat%0d", b));
        end

        // Single-beat bursts from each requester; the last one done is requester 0.
        applyStimulus(2'b10, 2'b10, 1'b1, 2'b00, 1'b0, "t6 r1 idle");
        applyStimulus(2'b10, 2'b10, 1'b1, 2'b10, 1'b0, "t6 r1 single");
        applyStimulus(2'b01, 2'b01, 1'b1, 2'b00, 1'b0, "t6 r0 idle");
        applyStimulus(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, "t6 r0 single");

        // Reset during beat 2 of a requester 0 burst.
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, "t7 idle");
        applyStimulus(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, "t7 beat1");
        req_valid = 2'b01;
        req_last  = 2'b00;
        out_ready = 1'b1;
        pushExpected(2'b01, 1'b0, "t7 beat2");
        @(negedge clk);
        checkOutput();
        #1;
        rst_n = 1'b0;
        #1;
        pushExpected(2'b00, 1'b0, "t7 async reset");
        checkOutput();
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After reset requester 0 wins a tie; then finish the stats traffic.
        applyStimulus(2'b11, 2'b11, 1'b1, 2'b00, 1'b0, "t8 tie idle");
        applyStimulus(2'b11, 2'b11, 1'b1, 2'b01, 1'b0, "t8 tie r0");
        applyStimulus(2'b10, 2'b10, 1'b1, 2'b10, 1'b0, "t8 tie r1");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b01, 2'b01, 1'b1, 2'b00, 1'b0, $sformatf("t8 r0 idle%0d", k));
            applyStimulus(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, $sformatf("t8 r0 burst%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(2'b10, 2'b10, 1'b1, 2'b00, 1'b0, $sformatf("t8 r1 idle%0d", k));
            applyStimulus(2'b10, 2'b10, 1'b1, 2'b10, 1'b0, $sformatf("t8 r1 burst%0d", k));
        end
        applyStimulus(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "t8 idle end");

`ifdef PE_SRC_ARB_STATS_EN
        // Since the last reset: 5 bursts granted to requester 0, 3 to requester 1.
        testsRun++;
        assert (grant_cnt0 === 16'd5) else begin
            testsFailed++;
            $error("[TB] FAIL stats grant_cnt0: observed %0d expected 5", grant_cnt0);
        end
        testsRun++;
        assert (grant_cnt1 === 16'd3) else begin
            testsFailed++;
            $error("[TB] FAIL stats grant_cnt1: observed %0d expected 3", grant_cnt1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
